sram_responder: RTL

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// sram_responder
//   Cycle-based model of an asynchronous-style SRAM sitting on a shared
//   16-bit bus, with a single memory-mapped I/O word at 20'h0FFFF.
//   Every bus input is sampled on the rising edge of Clk; reads and
//   writes each take WAIT_CYCLES clocks before data appears or commits.
//
// Parameters
//   DEPTH        number of 16-bit words in the array (power of two)
//   WAIT_CYCLES  access latency in clocks (1..15)
//
// Ports
//   Clk        in     single clock, rising edge
//   Reset      in     synchronous, active-high
//   Mem_CE     in     chip enable, active-low
//   Mem_OE     in     output enable, active-low
//   Mem_WE     in     write enable, active-low
//   Mem_UB     in     upper byte-lane enable, active-low
//   Mem_LB     in     lower byte-lane enable, active-low
//   ADDR       in     20-bit word address
//   Data       inout  shared data bus, high-Z unless driving read data
//   Switches   in     value returned by reads of the I/O word
//   HEX_out    out    register loaded by writes of the I/O word
//   Mem_Ready  out    read data valid / write committed
module sram_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  input  logic [15:0] Switches,
  output logic [15:0] HEX_out,
  output logic        Mem_Ready
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [19:0] IO_ADDR  = 20'h0FFFF;
  localparam logic [19:0] MEM_TOP  = 20'(DEPTH);
  localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_DRIVE = 3'd2,
    WR_WAIT  = 3'd3,
    WR_DONE  = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_nxt_s;
  logic [19:0]   addr_r;
  logic [19:0]   addr_nxt_s;
  logic [15:0]   rdata_r;
  logic [15:0]   hex_r;
  logic          drive_r;
  logic          ready_r;

  logic          bus_idle_s;
  logic          addr_io_s;
  logic          addr_mem_s;
  logic [AW-1:0] idx_s;
  logic [15:0]   mem_word_s;
  logic [15:0]   rd_word_s;
  logic          commit_s;
  logic          rd_load_s;

  logic [15:0]   mem_r [DEPTH];

  // New word after a byte-lane write: a lane whose active-low enable is 0
  // takes the bus byte, otherwise it keeps the old byte.
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_word,
                                              input logic [15:0] new_word,
                                              input logic        ub,
                                              input logic        lb);
    merge_lanes = {ub ? old_word[15:8] : new_word[15:8],
                   lb ? old_word[7:0]  : new_word[7:0]};
  endfunction

  // Read data as seen on the bus: a disabled lane reads as zero.
  function automatic logic [15:0] mask_lanes(input logic [15:0] word,
                                             input logic        ub,
                                             input logic        lb);
    mask_lanes = {ub ? 8'h00 : word[15:8],
                  lb ? 8'h00 : word[7:0]};
  endfunction

  // The bus is idle when deselected or when neither OE nor WE is asserted.
  assign bus_idle_s = Mem_CE | (Mem_OE & Mem_WE);

  // Address decode: the I/O word wins, then the in-range array window.
  assign addr_io_s  = (ADDR == IO_ADDR);
  assign addr_mem_s = !addr_io_s && (ADDR < MEM_TOP);
  assign idx_s      = ADDR[AW-1:0];
  assign mem_word_s = mem_r[idx_s];

  // Unmasked word the current address would return.
  always_comb begin
    rd_word_s = 16'h0000;
    if (addr_io_s) begin
      rd_word_s = Switches;
    end else if (addr_mem_s) begin
      rd_word_s = mem_word_s;
    end else begin
      rd_word_s = 16'h0000;
    end
  end

  // Next-state, counter, latched address and commit/load strobes.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    addr_nxt_s  = addr_r;
    commit_s    = 1'b0;
    rd_load_s   = 1'b0;
    if (Reset) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = 4'd0;
    end else if (bus_idle_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_nxt_s = CNT_LOAD;
          // Write has priority over read whatever OE says.
          if (!Mem_WE) begin
            state_nxt_s = WR_WAIT;
          end else begin
            state_nxt_s = RD_WAIT;
            addr_nxt_s  = ADDR;
          end
        end
        RD_WAIT, RD_DRIVE: begin
          if (!Mem_WE) begin
            // A write request ends the read; it starts from IDLE next edge.
            state_nxt_s = IDLE;
          end else if (ADDR != addr_r) begin
            // Address moved: release the bus and pay the full latency again.
            state_nxt_s = RD_WAIT;
            addr_nxt_s  = ADDR;
            cnt_nxt_s   = CNT_LOAD;
          end else if (state_r == RD_DRIVE) begin
            state_nxt_s = RD_DRIVE;
          end else if (cnt_r == 4'd0) begin
            state_nxt_s = RD_DRIVE;
            rd_load_s   = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r - 4'd1;
          end
        end
        WR_WAIT: begin
          if (Mem_WE) begin
            state_nxt_s = IDLE;
          end else if (cnt_r == 4'd0) begin
            state_nxt_s = WR_DONE;
            commit_s    = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r - 4'd1;
          end
        end
        WR_DONE: begin
          // Stay here until WE rises so one low pulse commits only once.
          if (Mem_WE) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = WR_DONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, counter, read-data and I/O registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= 20'h00000;
      rdata_r <= 16'h0000;
      drive_r <= 1'b0;
      ready_r <= 1'b0;
      hex_r   <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      addr_r  <= addr_nxt_s;
      drive_r <= (state_nxt_s == RD_DRIVE);
      ready_r <= (state_nxt_s == RD_DRIVE) || (state_nxt_s == WR_DONE);
      // Switches and lane enables are captured on the edge entering RD_DRIVE.
      if (rd_load_s) begin
        rdata_r <= mask_lanes(rd_word_s, Mem_UB, Mem_LB);
      end
      if (commit_s && addr_io_s) begin
        hex_r <= merge_lanes(hex_r, Data, Mem_UB, Mem_LB);
      end
    end
  end

  // Array write port; contents deliberately survive Reset.
  always_ff @(posedge Clk) begin
    if (commit_s && addr_mem_s) begin
      mem_r[idx_s] <= merge_lanes(mem_word_s, Data, Mem_UB, Mem_LB);
    end
  end

  assign Data      = drive_r ? rdata_r : 16'hzzzz;
  assign HEX_out   = hex_r;
  assign Mem_Ready = ready_r;

endmodule
